// File: rtl/usr_shift_pkg.sv
// usr_shift_pkg: shared command codes, chain select encodings and FSM states
// for the universal shift register controller.
// Build option: USR_SHIFT_ROTATE_EN (used by usr_shift_ctl) turns FILL=1 shifts
// into rotates.
package usr_shift_pkg;

  // Command codes presented on OP
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  // Select shared by every 4-bit slice of the chain
  typedef enum logic [1:0] {
    SEL_LOAD = 2'b00,
    SEL_SHR  = 2'b01,
    SEL_SHL  = 2'b10,
    SEL_HOLD = 2'b11
  } sel_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_FIN   = 2'b11
  } state_e;

  localparam int SLICE_BITS = 4;

  // Chain select used while a shift command is running
  function automatic sel_e shift_sel(input op_e op);
    return (op == OP_SHR) ? SEL_SHR : SEL_SHL;
  endfunction

endpackage

// File: rtl/usr_shift_chain.sv
// usr_shift_chain: WIDTH-bit register built from WIDTH/4 four-bit universal
// shift register slices that share one select. Bit 0 is the MSB; SHR moves
// data toward higher indices, SHL toward lower indices.
// Contents are not reset; the controller always reloads before use.
module usr_shift_chain
  import usr_shift_pkg::*;
#(
  parameter int WIDTH = 36
) (
  input  logic             CLK,
  input  sel_e             sel,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [0:WIDTH-1] d,
  output logic [0:WIDTH-1] q
);

  localparam int NSLICE = WIDTH / SLICE_BITS;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      logic [0:SLICE_BITS-1] s_q_reg;
      logic                  s_sr;
      logic                  s_sl;

      // Serial input toward higher index comes from the left neighbour's last bit
      if (gi == 0) begin : g_sr_edge
        assign s_sr = sr_in;
      end else begin : g_sr_link
        assign s_sr = q[gi*SLICE_BITS-1];
      end

      // Serial input toward lower index comes from the right neighbour's first bit
      if (gi == NSLICE - 1) begin : g_sl_edge
        assign s_sl = sl_in;
      end else begin : g_sl_link
        assign s_sl = q[(gi+1)*SLICE_BITS];
      end

      // One universal 4-bit slice: parallel load, shift either way, or hold
      always_ff @(posedge CLK) begin
        case (sel)
          SEL_LOAD: s_q_reg <= d[gi*SLICE_BITS +: SLICE_BITS];
          SEL_SHR:  s_q_reg <= {s_sr, s_q_reg[0:SLICE_BITS-2]};
          SEL_SHL:  s_q_reg <= {s_q_reg[1:SLICE_BITS-1], s_sl};
          default:  s_q_reg <= s_q_reg;
        endcase
      end

      assign q[gi*SLICE_BITS +: SLICE_BITS] = s_q_reg;
    end
  endgenerate

endmodule

// File: rtl/usr_shift_ctl.sv
// usr_shift_ctl: command controller around usr_shift_chain. A command is
// latched in IDLE, loaded into the chain, shifted COUNT times one bit per
// cycle, and the result is published on DOUT with a one-cycle DONE.
// Build option: define USR_SHIFT_ROTATE_EN to make FILL=1 shifts rotate.
module usr_shift_ctl
  import usr_shift_pkg::*;
#(
  parameter int WIDTH = 36
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [5:0]       COUNT,
  input  logic             FILL,
  input  logic [0:WIDTH-1] DIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [0:WIDTH-1] DOUT
);

  state_e           state_reg, state_next;
  op_e              op_reg;
  logic [5:0]       cnt_reg;
  logic             fill_reg;
  logic [0:WIDTH-1] din_reg;
  logic [0:WIDTH-1] dout_reg;
  sel_e             sel;
  logic             sr_in, sl_in;
  logic [0:WIDTH-1] chain_q;
  logic             accept;

  // A command is taken only from IDLE and never for NOP
  assign accept = (state_reg == ST_IDLE) && START && (op_e'(OP) != OP_NOP);

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic; SHIFT leaves after the cycle that uses the last count
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_LOAD;
      ST_LOAD:  state_next = (op_reg == OP_LOAD || cnt_reg == 6'd0) ? ST_FIN : ST_SHIFT;
      ST_SHIFT: if (cnt_reg == 6'd1) state_next = ST_FIN;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; DOUT shows the chain during FIN so it is valid alongside DONE
  always_comb begin
    sel  = SEL_HOLD;
    BUSY = 1'b0;
    DONE = 1'b0;
    DOUT = dout_reg;
    case (state_reg)
      ST_LOAD: begin
        sel  = SEL_LOAD;
        BUSY = 1'b1;
      end
      ST_SHIFT: begin
        sel  = shift_sel(op_reg);
        BUSY = 1'b1;
      end
      ST_FIN: begin
        DONE = 1'b1;
        DOUT = chain_q;
      end
      default: ;
    endcase
  end

  // Command latch, remaining-count register and result capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_reg   <= OP_NOP;
      cnt_reg  <= 6'd0;
      fill_reg <= 1'b0;
      din_reg  <= '0;
      dout_reg <= '0;
    end else begin
      if (accept) begin
        op_reg   <= op_e'(OP);
        cnt_reg  <= COUNT;
        fill_reg <= FILL;
        din_reg  <= DIN;
      end else if (state_reg == ST_SHIFT) begin
        cnt_reg <= cnt_reg - 6'd1;
      end
      if (state_reg == ST_FIN) dout_reg <= chain_q;
    end
  end

`ifdef USR_SHIFT_ROTATE_EN
  // FILL=1 wraps the outgoing edge bit back in; FILL=0 still shifts in zeros
  assign sr_in = fill_reg ? chain_q[WIDTH-1] : 1'b0;
  assign sl_in = fill_reg ? chain_q[0]       : 1'b0;
`else
  assign sr_in = fill_reg;
  assign sl_in = fill_reg;
`endif

  usr_shift_chain #(.WIDTH(WIDTH)) u_chain (
    .CLK   (CLK),
    .sel   (sel),
    .sr_in (sr_in),
    .sl_in (sl_in),
    .d     (din_reg),
    .q     (chain_q)
  );

endmodule

// File: tb/tb_usr_shift_ctl.sv
// tb_usr_shift_ctl: directed and random commands against an arithmetic model
// of the shift/rotate rules, with latency and BUSY-length checks.
module tb_usr_shift_ctl;

  localparam int W = 36;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [1:0]   OP;
  logic [5:0]   COUNT;
  logic         FILL;
  logic [0:W-1] DIN;
  logic         BUSY;
  logic         DONE;
  logic [0:W-1] DOUT;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_dout;
  int last_lat;
  int last_busy;

  usr_shift_ctl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .OP    (OP),
    .COUNT (COUNT),
    .FILL  (FILL),
    .DIN   (DIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .DOUT  (DOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Numeric view: index 0 is the MSB, so SHR is a right shift of the value.
  function automatic logic [W-1:0] model(input logic [1:0] op, input int c,
                                         input logic f, input logic [W-1:0] v);
    logic [W-1:0] ones;
    int r;
    ones = '1;
    if (op == 2'b00) return v;
`ifdef USR_SHIFT_ROTATE_EN
    if (f) begin
      r = c % W;
      if (r == 0) return v;
      if (op == 2'b01) return (v >> r) | (v << (W - r));
      return (v << r) | (v >> (W - r));
    end
`endif
    if (op == 2'b01) return (v >> c) | (f ? ~(ones >> c) : '0);
    return (v << c) | (f ? ~(ones << c) : '0);
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] cnt, input logic f,
                         input logic [W-1:0] v, input bit hold);
    logic [W-1:0] exp_d;
    int exp_lat;
    int n;
    int busy_n;
    exp_d   = model(op, int'(cnt), f, v);
    exp_lat = (op == 2'b00) ? 2 : int'(cnt) + 2;
    @(negedge CLK);
    START = 1'b1; OP = op; COUNT = cnt; FILL = f; DIN = v;
    @(posedge CLK); #1;
    if (!hold) START = 1'b0;
    n = 1;
    busy_n = 0;
    while (DONE !== 1'b1 && n < 200) begin
      if (BUSY === 1'b1) busy_n++;
      if (hold) begin
        OP    = 2'($urandom_range(0, 2));
        DIN   = W'({$urandom, $urandom});
        COUNT = 6'($urandom);
        FILL  = 1'($urandom);
      end
      @(posedge CLK); #1;
      n++;
    end
    START = 1'b0;
    last_dout = DOUT;
    last_lat  = n;
    last_busy = busy_n;
    chk("latency", 64'(n), 64'(exp_lat));
    chk("busy_in_done", 64'(BUSY), 64'd0);
    chk("dout", 64'(last_dout), 64'(exp_d));
    chk("busy_cycles", 64'(busy_n), 64'(exp_lat - 1));
    @(posedge CLK); #1;
    chk("done_pulse", 64'(DONE), 64'd0);
    chk("dout_hold", 64'(DOUT), 64'(exp_d));
    $display("cmd op=%0d cnt=%0d fill=%0d din=%o dout=%o lat=%0d busy=%0d",
             op, cnt, f, v, last_dout, n, busy_n);
  endtask

  initial begin
    int busy_seen;
    int done_seen;
    RESET = 1'b1; START = 1'b0; OP = 2'b11; COUNT = '0; FILL = 1'b0; DIN = '0;
    #12;
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_dout", 64'(DOUT), 64'd0);
    @(negedge CLK); RESET = 1'b0;

    // Directed cases
    run_cmd(2'b00, 6'd7, 1'b0, 36'o123456701234, 1'b0);
    chk("load_lit", 64'(last_dout), 64'(36'o123456701234));
    run_cmd(2'b01, 6'd3, 1'b0, 36'o400000000000, 1'b0);
    chk("shr3_lit", 64'(last_dout), 64'(36'o040000000000));
    run_cmd(2'b10, 6'd40, 1'b1, 36'o252525252525, 1'b0);
    chk("shl40_lit", 64'(last_dout), 64'(36'o777777777777));
    chk("shl40_busy", 64'(last_busy), 64'd41);
    run_cmd(2'b01, 6'd63, 1'b0, 36'o777777777777, 1'b0);
    run_cmd(2'b10, 6'd36, 1'b0, 36'o777777777777, 1'b0);
    run_cmd(2'b10, 6'd0, 1'b0, 36'o1, 1'b0);
    chk("shl0_lit", 64'(last_dout), 64'(36'o1));
    chk("shl0_lat", 64'(last_lat), 64'd2);

    // NOP is ignored
    @(negedge CLK); START = 1'b1; OP = 2'b11; COUNT = 6'd5; DIN = '1;
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (BUSY === 1'b1 || DONE === 1'b1) busy_seen++;
    end
    START = 1'b0;
    chk("nop_ignored", 64'(busy_seen), 64'd0);
    chk("nop_dout", 64'(DOUT), 64'(36'o1));

    // Reset in the middle of a shift discards the command
    @(negedge CLK); START = 1'b1; OP = 2'b01; COUNT = 6'd20; FILL = 1'b1; DIN = '0;
    @(posedge CLK); #1; START = 1'b0;
    repeat (5) @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    chk("midrst_busy", 64'(BUSY), 64'd0);
    chk("midrst_done", 64'(DONE), 64'd0);
    chk("midrst_dout", 64'(DOUT), 64'd0);
    @(negedge CLK); RESET = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1 || BUSY === 1'b1) done_seen++;
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);
    chk("midrst_dout_after", 64'(DOUT), 64'd0);

    // START held (with changing inputs) while busy must not disturb the command
    run_cmd(2'b10, 6'd5, 1'b1, 36'o123400000000, 1'b1);
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (BUSY === 1'b1) busy_seen++;
    end
    chk("held_start_idle", 64'(busy_seen), 64'd0);

`ifdef USR_SHIFT_ROTATE_EN
    run_cmd(2'b01, 6'd1, 1'b1, 36'o1, 1'b0);
    chk("rot_shr1_lit", 64'(last_dout), 64'(36'o400000000000));
`endif

    // Random commands against the model
    for (int k = 0; k < 20; k++) begin
      run_cmd(2'($urandom_range(0, 2)), 6'($urandom_range(0, 45)), 1'($urandom),
              W'({$urandom, $urandom}), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usr_shift_ctl.md
USR_SHIFT_CTL -- requirements
Module: usr_shift_ctl

Interface
REQ-001 SHALL have parameter WIDTH, default 36, giving the register width in bits; WIDTH is a multiple of 4.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port START, input, 1 bit: command strobe.
REQ-005 SHALL have port OP, input, 2 bits: command code; 00 LOAD, 01 SHR (toward higher bit index), 10 SHL, 11 NOP.
REQ-006 SHALL have port COUNT, input, 6 bits: shift distance, 0..63.
REQ-007 SHALL have port FILL, input, 1 bit: bit shifted into the vacated end.
REQ-008 SHALL have port DIN, input, [0:WIDTH-1]: operand, bit 0 = MSB.
REQ-009 SHALL have port BUSY, output, 1 bit: command in progress.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port DOUT, output, [0:WIDTH-1]: captured result.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, FIN.
REQ-013 IDLE with START=1 and OP!=NOP SHALL latch OP, COUNT, FILL and DIN, set BUSY, and go to LOAD.
REQ-014 START with OP=NOP SHALL be ignored; START outside IDLE SHALL be ignored.
REQ-015 LOAD SHALL drive chain SEL=00 for one cycle, then go to FIN if OP=LOAD or COUNT=0, else to SHIFT.
REQ-016 SHIFT SHALL drive SEL=01 (SHR) or SEL=10 (SHL) once per cycle, decrementing a remaining-count register, and go to FIN after exactly COUNT shift cycles.
REQ-017 In all other states and cycles, chain SEL SHALL be 11 (HOLD).
REQ-018 SHR SHALL feed the latched FILL into bit 0; SHL SHALL feed it into bit WIDTH-1; slice-to-slice carries SHALL connect each slice's edge bits to its neighbours.
REQ-019 FIN SHALL copy the chain into DOUT, pulse DONE for one cycle, clear BUSY, and return to IDLE.
REQ-020 Total latency from the START cycle to the DONE cycle SHALL be COUNT+2 for shifts and 2 for LOAD.
REQ-021 COUNT >= WIDTH SHALL yield DOUT of all FILL bits, with no saturation or wrap of the count.
REQ-022 DOUT SHALL hold its value between commands.

Reset
REQ-023 RESET SHALL force the FSM to IDLE, clear BUSY, DONE, DOUT and the count register, and drive SEL=11, at any time including mid-command.
REQ-024 The chain contents after reset SHALL be don't-care; a discarded command SHALL produce no DONE.

Configuration
REQ-025 With USR_SHIFT_ROTATE_EN defined, a FILL=1 shift command SHALL rotate instead: SHR feeds bit WIDTH-1 into bit 0, and SHL feeds bit 0 into bit WIDTH-1.
REQ-026 Without USR_SHIFT_ROTATE_EN, FILL SHALL always be shifted in literally.

Structure
REQ-027 Package usr_shift_pkg SHALL hold the OP codes, the SEL encodings (LOAD/SHR/SHL/HOLD) and the FSM state enum.
REQ-028 Sub-module usr_shift_chain SHALL build the WIDTH-bit register from WIDTH/4 four-bit universal shift register slices sharing one SEL.

Verification
REQ-029 LOAD, DIN=36'o123456701234 -> DONE 2 cycles after START; DOUT=36'o123456701234.
REQ-030 SHR, COUNT=3, FILL=0, DIN=36'o400000000000 -> DONE at cycle 5; DOUT=36'o040000000000.
REQ-031 SHL, COUNT=40, FILL=1, any DIN -> DOUT=36'o777777777777; BUSY high exactly 41 cycles.
REQ-032 SHL, COUNT=0, DIN=36'o1 -> DONE at cycle 2; DOUT=36'o1.
REQ-033 RESET asserted mid-SHIFT, then START held during BUSY -> no DONE, DOUT=0, and the held START is ignored until IDLE.
REQ-034 With USR_SHIFT_ROTATE_EN defined: SHR, COUNT=1, FILL=1, DIN=36'o1 -> DOUT=36'o400000000000.
